mac_weight_loader: RTL and testbench

MAC_WEIGHT_LOADER -- requirements
Module: mac_weight_loader

---
 rtl/mac_weight_loader_if.sv | 29 ++
 rtl/mac_weight_loader.sv | 103 ++++++++++
 tb/tb_mac_weight_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_weight_loader_if.sv
// Weight-loader bus: load request, weight word stream and the
// per-array weight/slot-enable outputs toward the systolic arrays.
interface mac_weight_loader_if #(
  parameter int ARRAY_NUM = 32,
  parameter int SLOT_NUM  = 10
);
  logic                          start;
  logic [1:0]                    bank_sel;
  logic                          w_valid;
  logic [31:0]                   w_data;
  logic                          w_ready;
  logic [ARRAY_NUM*8-1:0]        weight_load;
  logic [ARRAY_NUM*SLOT_NUM-1:0] weight_load_en;
  logic [1:0]                    weight_load_sel;
  logic                          busy;
  logic                          done;

  // Producer / controller side
  modport master (
    output start, bank_sel, w_valid, w_data,
    input  w_ready, weight_load, weight_load_en, weight_load_sel, busy, done
  );

  // Loader side
  modport slave (
    input  start, bank_sel, w_valid, w_data,
    output w_ready, weight_load, weight_load_en, weight_load_sel, busy, done
  );
endinterface

// File: rtl/mac_weight_loader.sv
// Weight loader: collects ARRAY_NUM/4 words (4 bytes each) per slot into a
// staging register, then pulses one slot-write to every systolic array.
// Repeats for SLOT_NUM slots into the bank latched at start.
module mac_weight_loader #(
  parameter int ARRAY_NUM = 32,
  parameter int SLOT_NUM  = 10
) (
  input  logic                clk,
  input  logic                rst,
  mac_weight_loader_if.slave  bus
);
  localparam int WORDS = ARRAY_NUM / 4;
  localparam int JW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int KW    = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(WORDS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(SLOT_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t                        r_state, w_state_nxt;
  logic [JW-1:0]                 r_j;
  logic [KW-1:0]                 r_k;
  logic [1:0]                    r_sel;
  logic [ARRAY_NUM*8-1:0]        r_stage, w_stage_nxt, r_weight_load;
  logic [ARRAY_NUM*SLOT_NUM-1:0] r_load_en, w_load_en_nxt;
  logic                          w_xfer, w_last_word;

  assign w_xfer      = (r_state == S_COLLECT) && bus.w_valid;
  assign w_last_word = w_xfer && (r_j == J_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_last_word) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = (r_k == K_LAST) ? S_DONE : S_COLLECT;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Word/slot counters and bank latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_j   <= '0;
      r_k   <= '0;
      r_sel <= 2'd0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_j   <= '0;
        r_k   <= '0;
        r_sel <= bus.bank_sel;
      end
      if (w_xfer) r_j <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
      if (r_state == S_WRITE && r_k != K_LAST) r_k <= r_k + 1'b1;
    end
  end

  // Word j lands in the staging bytes of arrays 4j..4j+3
  always_comb begin
    w_stage_nxt = r_stage;
    if (w_xfer) begin
      for (int b = 0; b < 4; b++)
        w_stage_nxt[(int'(r_j) * 4 + b) * 8 +: 8] = bus.w_data[b * 8 +: 8];
    end
  end

  // Slot-k enable for every array, raised for the cycle spent in WRITE
  always_comb begin
    w_load_en_nxt = '0;
    if (w_last_word) begin
      for (int i = 0; i < ARRAY_NUM; i++)
        w_load_en_nxt[i * SLOT_NUM + int'(r_k)] = 1'b1;
    end
  end

  // Staging and output registers; weight_load includes the final word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage       <= '0;
      r_weight_load <= '0;
      r_load_en     <= '0;
    end else begin
      r_stage   <= w_stage_nxt;
      r_load_en <= w_load_en_nxt;
      if (w_last_word) r_weight_load <= w_stage_nxt;
    end
  end

  assign bus.w_ready         = (r_state == S_COLLECT);
  assign bus.busy            = (r_state == S_COLLECT) || (r_state == S_WRITE);
  assign bus.done            = (r_state == S_DONE);
  assign bus.weight_load     = r_weight_load;
  assign bus.weight_load_en  = r_load_en;
  assign bus.weight_load_sel = r_sel;
endmodule

// File: tb/tb_mac_weight_loader.sv
// Scoreboard bench for mac_weight_loader: expected slot writes and done
// pulses are queued when a load is issued; a monitor compares them.
module tb_mac_weight_loader;
  localparam int AN = 32;
  localparam int SN = 10;
  localparam int EW = AN * SN;

  logic clk;
  logic rst;

  mac_weight_loader_if #(.ARRAY_NUM(AN), .SLOT_NUM(SN)) bus ();

  mac_weight_loader #(.ARRAY_NUM(AN), .SLOT_NUM(SN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              kind;   // 0 = slot write, 1 = done
    int              gap;    // cycles since previous event, 0 = unchecked
    logic [AN*8-1:0] data;
    logic [EW-1:0]   en;
    logic [1:0]      sel;
    bit              ident;  // slot 0: byte i must equal i
  } exp_t;

  exp_t            q[$];
  exp_t            me;
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              last_cyc = 0;
  logic [AN*8-1:0] ident;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int n);
    return 32'h03020100 + 32'(32'h04040404 * n);
  endfunction

  task automatic push_load(input logic [1:0] sel, input int nslots, input int gap, input bit with_done);
    exp_t        e;
    logic [31:0] w;
    for (int s = 0; s < nslots; s++) begin
      e.kind  = 0;
      e.gap   = (s == 0) ? 0 : gap;
      e.sel   = sel;
      e.en    = '0;
      e.data  = '0;
      e.ident = (s == 0);
      for (int i = 0; i < AN; i++) begin
        e.en[i * SN + s] = 1'b1;
        w = word(s * 8 + i / 4);
        e.data[i * 8 +: 8] = w[(i % 4) * 8 +: 8];
      end
      q.push_back(e);
    end
    if (with_done) begin
      e.kind  = 1;
      e.gap   = 1;
      e.en    = '0;
      e.ident = 0;
      q.push_back(e);
    end
  endtask

  // Monitor: every slot write or done pulse must match the queue head
  always @(negedge clk) begin
    if (rst) begin
      last_cyc = 0;
    end else begin
      cyc++;
      if (bus.weight_load_en != '0 || bus.done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: en=%0h done=%0b expected none", bus.weight_load_en, bus.done);
        end else begin
          me = q.pop_front();
          check("event_kind", bus.done, me.kind == 1);
          check("event_sel", bus.weight_load_sel, me.sel);
          check("event_ready", bus.w_ready, 0);
          check("event_en", bus.weight_load_en, me.en);
          if (me.kind == 0) begin
            check("write_data", bus.weight_load, me.data);
            check("write_busy", bus.busy, 1);
            if (me.ident) check("slot0_ident", bus.weight_load, ident);
          end else begin
            check("done_busy", bus.busy, 0);
          end
          if (me.gap != 0) check("event_gap", cyc - last_cyc, me.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, bus.w_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_wload"}, bus.weight_load, 0);
    check({tag, "_en"}, bus.weight_load_en, 0);
    check({tag, "_sel"}, bus.weight_load_sel, 0);
  endtask

  task automatic do_start(input logic [1:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.bank_sel = b;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("sel_latched", bus.weight_load_sel, b);
  endtask

  // Drive words until 'stop' transfers are committed; gap mode drops
  // w_valid for one COLLECT cycle before each word, otherwise w_valid is
  // held high (including through WRITE) for 'extra' cycles after the end.
  task automatic send(input bit gap, input bit inj, input int stop, input int extra);
    int n   = 0;
    int tmo = 0;
    bit tog = 0;
    bit injd = 0;
    bit v;
    while (n < stop) begin
      @(negedge clk);
      tmo++;
      if (tmo > 3000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got %0d words expected %0d", n, stop);
        break;
      end
      bus.start = 1'b0;
      if (inj && n == 36 && !injd) begin
        bus.start    = 1'b1;
        bus.bank_sel = 2'd1;
        injd         = 1;
      end
      if (gap) begin
        if (bus.w_ready) begin
          v   = tog;
          tog = !tog;
        end else begin
          v = 1'b0;
        end
      end else begin
        v = 1'b1;
      end
      bus.w_valid = v;
      bus.w_data  = word(n);
      if (v && bus.w_ready) n++;
    end
    repeat (extra) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.w_data = 32'hDEADBEEF;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.w_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (q.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain"}, q.size(), 0);
    repeat (3) @(negedge clk);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_idle_ready"}, bus.w_ready, 0);
  endtask

  initial begin
    for (int i = 0; i < AN; i++) ident[i * 8 +: 8] = 8'(i);
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.bank_sel = 2'd0;
    bus.w_valid  = 1'b0;
    bus.w_data   = 32'd0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Back-to-back words, w_valid held high through WRITE/DONE
    push_load(2'd2, SN, 9, 1);
    do_start(2'd2);
    send(0, 0, 80, 4);
    drain("t1");

    // w_valid low every other COLLECT cycle
    push_load(2'd2, SN, 17, 1);
    do_start(2'd2);
    send(1, 0, 80, 0);
    drain("t2");

    // Second start during slot 4 is ignored
    push_load(2'd2, SN, 9, 1);
    do_start(2'd2);
    send(0, 1, 80, 0);
    drain("t3");
    check("t3_sel_kept", bus.weight_load_sel, 2);

    // Reset after the slot-3 write abandons the load
    push_load(2'd3, 4, 9, 0);
    do_start(2'd3);
    send(0, 0, 32, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_queue", q.size(), 0);

    // Fresh load restarts at slot 0
    push_load(2'd1, SN, 9, 1);
    do_start(2'd1);
    send(0, 0, 80, 0);
    drain("t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
